// File: rtl/arbitro_memoria.sv
// Memory sequencer/arbiter: shares one 256x8 synchronous RAM between nRisc fetch, nRisc data and a program loader.
// Optional build macro ARB_PERF_CNT_EN adds saturating instruction/loader-grant counters.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_FETCH  | drive pc_addr to memory (or enter S_HALT on pc 0xFF)
// S_FWAIT  | capture instruction from mem_rdata
// S_EXEC   | store (write) / issue load read / nothing
// S_DWAIT  | capture load data from mem_rdata
// S_COMMIT | core_en pulse, burst count cleared, loader may follow
// S_LOAD   | loader write, bounded by MAX_LD_BURST
// S_HALT   | core parked, loader served every cycle until reset
module arbitro_memoria #(
   parameter int unsigned MAX_LD_BURST = 4
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic [7:0] pc_addr,
   output logic [7:0] instr_out,
   output logic       core_en,
   input  logic       d_rd,
   input  logic       d_wr,
   input  logic [7:0] d_addr,
   input  logic [7:0] d_wdata,
   output logic [7:0] d_rdata,
   input  logic       ld_req,
   input  logic [7:0] ld_addr,
   input  logic [7:0] ld_wdata,
   output logic       ld_gnt,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic       mem_we,
   input  logic [7:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [15:0] instr_count,
   output logic [15:0] ld_count
`endif
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_FWAIT  = 3'd1,
      S_EXEC   = 3'd2,
      S_DWAIT  = 3'd3,
      S_COMMIT = 3'd4,
      S_LOAD   = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   localparam logic [3:0] MAX_B = 4'(MAX_LD_BURST);

   state_t     state_q, state_d;
   logic [7:0] instr_q, instr_d;
   logic [7:0] d_rdata_q, d_rdata_d;
   logic [3:0] burst_q, burst_d;

   logic [7:0] addr_c, wdata_c;
   logic       we_c, ce_c, gnt_c;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= S_FETCH;
         instr_q   <= 8'h00;
         d_rdata_q <= 8'h00;
         burst_q   <= 4'd0;
      end else begin
         state_q   <= state_d;
         instr_q   <= instr_d;
         d_rdata_q <= d_rdata_d;
         burst_q   <= burst_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      d_rdata_d = d_rdata_q;
      burst_d   = burst_q;
      addr_c    = 8'h00;
      wdata_c   = 8'h00;
      we_c      = 1'b0;
      ce_c      = 1'b0;
      gnt_c     = 1'b0;
      case (state_q)
         S_FETCH: begin
            addr_c  = pc_addr;
            state_d = (pc_addr == 8'hFF) ? S_HALT : S_FWAIT;
         end
         S_FWAIT: begin
            instr_d = mem_rdata;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            // store takes precedence when both strobes are set
            if (d_wr) begin
               addr_c  = d_addr;
               wdata_c = d_wdata;
               we_c    = 1'b1;
               state_d = S_COMMIT;
            end else if (d_rd) begin
               addr_c  = d_addr;
               state_d = S_DWAIT;
            end else begin
               state_d = S_COMMIT;
            end
         end
         S_DWAIT: begin
            d_rdata_d = mem_rdata;
            state_d   = S_COMMIT;
         end
         S_COMMIT: begin
            ce_c    = 1'b1;
            burst_d = 4'd0;
            state_d = ld_req ? S_LOAD : S_FETCH;
         end
         S_LOAD: begin
            // a request withdrawn before its grant cycle gets no write
            if (ld_req) begin
               addr_c  = ld_addr;
               wdata_c = ld_wdata;
               we_c    = 1'b1;
               gnt_c   = 1'b1;
               burst_d = burst_q + 4'd1;
               state_d = (burst_d < MAX_B) ? S_LOAD : S_FETCH;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_HALT: begin
            if (ld_req) begin
               addr_c  = ld_addr;
               wdata_c = ld_wdata;
               we_c    = 1'b1;
               gnt_c   = 1'b1;
            end
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Gated by reset so an in-flight write is dropped the moment reset asserts.
   assign mem_addr  = RESET_N ? addr_c  : 8'h00;
   assign mem_wdata = RESET_N ? wdata_c : 8'h00;
   assign mem_we    = RESET_N & we_c;
   assign core_en   = RESET_N & ce_c;
   assign ld_gnt    = RESET_N & gnt_c;
   assign instr_out = instr_q;
   assign d_rdata   = d_rdata_q;

`ifdef ARB_PERF_CNT_EN
   logic [15:0] instr_cnt_q, ld_cnt_q;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         instr_cnt_q <= 16'h0000;
         ld_cnt_q    <= 16'h0000;
      end else begin
         if (core_en && (instr_cnt_q != 16'hFFFF))
            instr_cnt_q <= instr_cnt_q + 16'd1;
         if (ld_gnt && (ld_cnt_q != 16'hFFFF))
            ld_cnt_q <= ld_cnt_q + 16'd1;
      end
   end

   assign instr_count = instr_cnt_q;
   assign ld_count    = ld_cnt_q;
`endif

endmodule

// File: tb/tb_arbitro_memoria.sv
// Testbench for arbitro_memoria: per-instruction cycle templates build the expected
// output trace for each directed scenario, compared against the DUT on every cycle.
module tb_arbitro_memoria;

   localparam int MAXB = 4;
   localparam int NMAX = 64;

   logic       CLK = 1'b0;
   logic       RESET_N;
   logic [7:0] pc_addr, d_addr, d_wdata, ld_addr, ld_wdata, mem_rdata;
   logic       d_rd, d_wr, ld_req;
   logic [7:0] instr_out, d_rdata, mem_addr, mem_wdata;
   logic       core_en, ld_gnt, mem_we;
`ifdef ARB_PERF_CNT_EN
   logic [15:0] instr_count, ld_count;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   arbitro_memoria #(.MAX_LD_BURST(MAXB)) dut (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .pc_addr   (pc_addr),
      .instr_out (instr_out),
      .core_en   (core_en),
      .d_rd      (d_rd),
      .d_wr      (d_wr),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata),
      .ld_req    (ld_req),
      .ld_addr   (ld_addr),
      .ld_wdata  (ld_wdata),
      .ld_gnt    (ld_gnt),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata)
`ifdef ARB_PERF_CNT_EN
      ,
      .instr_count (instr_count),
      .ld_count    (ld_count)
`endif
   );

   // Synchronous RAM with a preload port used only while the DUT is in reset.
   logic [7:0] mem [256];
   logic       pl_we = 1'b0;
   logic [7:0] pl_addr = 8'h00, pl_data = 8'h00;

   always @(posedge CLK) begin
      if (pl_we)       mem[pl_addr]  <= pl_data;
      else if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   // Reference memory image and expected per-cycle trace.
   logic [7:0] mm [256];
   logic       exp_ce [NMAX], exp_gnt [NMAX], exp_we [NMAX], exp_ca [NMAX];
   logic [7:0] exp_addr [NMAX], exp_wd [NMAX], exp_ins [NMAX], exp_drd [NMAX];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic void put(input int t, input logic ce, input logic gnt, input logic we,
                               input logic ca, input logic [7:0] a, input logic [7:0] wd,
                               input logic [7:0] ins, input logic [7:0] drd);
      if (t < NMAX) begin
         exp_ce[t] = ce;  exp_gnt[t] = gnt; exp_we[t]  = we;  exp_ca[t]  = ca;
         exp_addr[t] = a; exp_wd[t]  = wd;  exp_ins[t] = ins; exp_drd[t] = drd;
      end
   endfunction

   // Inputs are constant for a scenario, so the trace is a repetition of
   // instruction templates (4 or 5 cycles) each followed by an optional loader burst.
   task automatic build_model(input int n);
      int t;
      logic [7:0] ins, drd;
      t = 0; ins = 8'h00; drd = 8'h00;
      for (int i = 0; i < NMAX; i++) put(i, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00);
      while (t < n) begin
         if (pc_addr == 8'hFF) begin
            put(t, 0, 0, 0, 1, pc_addr, 8'h00, ins, drd); t++;
            while (t < n) begin
               if (ld_req) begin
                  mm[ld_addr] = ld_wdata;
                  put(t, 0, 1, 1, 1, ld_addr, ld_wdata, ins, drd);
               end else begin
                  put(t, 0, 0, 0, 0, 8'h00, 8'h00, ins, drd);
               end
               t++;
            end
         end else begin
            put(t, 0, 0, 0, 1, pc_addr, 8'h00, ins, drd); t++;
            put(t, 0, 0, 0, 0, 8'h00, 8'h00, ins, drd); t++;
            ins = mm[pc_addr];
            if (d_wr) begin
               mm[d_addr] = d_wdata;
               put(t, 0, 0, 1, 1, d_addr, d_wdata, ins, drd); t++;
            end else if (d_rd) begin
               put(t, 0, 0, 0, 1, d_addr, 8'h00, ins, drd); t++;
               put(t, 0, 0, 0, 0, 8'h00, 8'h00, ins, drd); t++;
               drd = mm[d_addr];
            end else begin
               put(t, 0, 0, 0, 0, 8'h00, 8'h00, ins, drd); t++;
            end
            put(t, 1, 0, 0, 0, 8'h00, 8'h00, ins, drd); t++;
            if (ld_req) begin
               for (int g = 0; g < MAXB; g++) begin
                  mm[ld_addr] = ld_wdata;
                  put(t, 0, 1, 1, 1, ld_addr, ld_wdata, ins, drd); t++;
               end
            end
         end
      end
   endtask

   function automatic int count_gnt(input int a, input int b);
      int c = 0;
      for (int i = a; i <= b; i++) if (exp_gnt[i]) c++;
      return c;
   endfunction

   function automatic int count_ce(input int a, input int b);
      int c = 0;
      for (int i = a; i <= b; i++) if (exp_ce[i]) c++;
      return c;
   endfunction

   task automatic compare_cycle(input int t);
      chk($sformatf("core_en@%0d", t),   {7'b0, core_en}, {7'b0, exp_ce[t]});
      chk($sformatf("ld_gnt@%0d", t),    {7'b0, ld_gnt},  {7'b0, exp_gnt[t]});
      chk($sformatf("mem_we@%0d", t),    {7'b0, mem_we},  {7'b0, exp_we[t]});
      chk($sformatf("instr_out@%0d", t), instr_out, exp_ins[t]);
      chk($sformatf("d_rdata@%0d", t),   d_rdata,   exp_drd[t]);
      if (exp_ca[t]) chk($sformatf("mem_addr@%0d", t), mem_addr, exp_addr[t]);
      if (exp_we[t]) chk($sformatf("mem_wdata@%0d", t), mem_wdata, exp_wd[t]);
   endtask

   task automatic zero_check(input string tag);
      chk({tag, "_instr_out"}, instr_out, 8'h00);
      chk({tag, "_d_rdata"},   d_rdata,   8'h00);
      chk({tag, "_mem_addr"},  mem_addr,  8'h00);
      chk({tag, "_mem_wdata"}, mem_wdata, 8'h00);
      chk({tag, "_ctl"}, {5'b0, core_en, ld_gnt, mem_we}, 8'h00);
   endtask

   task automatic poke(input logic [7:0] a, input logic [7:0] d);
      pl_we = 1'b1; pl_addr = a; pl_data = d; mm[a] = d;
      @(posedge CLK); #1;
      pl_we = 1'b0;
   endtask

   task automatic begin_scn(input logic [7:0] pc, input logic rd, input logic wr,
                            input logic [7:0] da, input logic [7:0] dw, input logic lr,
                            input logic [7:0] la, input logic [7:0] lw);
      RESET_N = 1'b0;
      pc_addr = pc; d_rd = rd; d_wr = wr; d_addr = da; d_wdata = dw;
      ld_req = lr; ld_addr = la; ld_wdata = lw;
      for (int a = 0; a < 256; a++) poke(8'(a), 8'(a) ^ 8'h5A);
      zero_check("reset");
   endtask

   // Release reset just after a rising edge; the following low phase is cycle 0.
   task automatic run(input int n);
      @(posedge CLK); #1;
      RESET_N = 1'b1;
      for (int t = 0; t < n; t++) begin
         @(negedge CLK);
         compare_cycle(t);
      end
   endtask

   initial begin
      RESET_N = 1'b0;
      pc_addr = 8'h00; d_rd = 1'b0; d_wr = 1'b0; d_addr = 8'h00; d_wdata = 8'h00;
      ld_req = 1'b0; ld_addr = 8'h00; ld_wdata = 8'h00;

      // Plain instruction
      begin_scn(8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
      poke(8'h00, 8'h20);
      build_model(12);
      chk("model_ins1", exp_ins[1], 8'h00);
      chk("model_ins2", exp_ins[2], 8'h20);
      chk("model_ce_count", 8'(count_ce(0, 7)), 8'd2);
      chk("model_ce3", {7'b0, exp_ce[3]}, 8'h01);
      chk("model_fetch4", {7'b0, exp_ca[4]}, 8'h01);
      run(12);

      // Load
      begin_scn(8'h01, 1, 0, 8'h10, 8'h00, 0, 8'h00, 8'h00);
      poke(8'h10, 8'hAB);
      build_model(15);
      chk("model_ld_addr2", exp_addr[2], 8'h10);
      chk("model_drd3", exp_drd[3], 8'h00);
      chk("model_drd4", exp_drd[4], 8'hAB);
      chk("model_ld_ce4", {7'b0, exp_ce[4]}, 8'h01);
      run(15);

      // Store
      begin_scn(8'h02, 0, 1, 8'h05, 8'h3C, 0, 8'h00, 8'h00);
      build_model(12);
      chk("model_st_we2", {7'b0, exp_we[2]}, 8'h01);
      chk("model_st_we3", {7'b0, exp_we[3]}, 8'h00);
      chk("model_st_ce3", {7'b0, exp_ce[3]}, 8'h01);
      run(12);
      chk("mem05_after_store", mem[8'h05], 8'h3C);

      // Read and write strobes together: the write wins
      begin_scn(8'h03, 1, 1, 8'h07, 8'hC5, 0, 8'h00, 8'h00);
      build_model(8);
      run(8);
      chk("mem07_after_rdwr", mem[8'h07], 8'hC5);

      // Loader held high: bursts of MAXB grants interleaved with one instruction
      begin_scn(8'h00, 0, 0, 8'h00, 8'h00, 1, 8'h40, 8'h99);
      poke(8'h00, 8'h20);
      build_model(24);
      chk("model_burst1", 8'(count_gnt(4, 7)), 8'd4);
      chk("model_gap8", {7'b0, exp_gnt[8]}, 8'h00);
      chk("model_ce11", {7'b0, exp_ce[11]}, 8'h01);
      chk("model_burst2", 8'(count_gnt(12, 15)), 8'd4);
      run(24);
      chk("mem40_after_burst", mem[8'h40], 8'h99);

      // Halt with loader active
      begin_scn(8'hFF, 0, 0, 8'h00, 8'h00, 1, 8'h30, 8'h77);
      build_model(25);
      chk("model_halt_ce", 8'(count_ce(0, 24)), 8'd0);
      chk("model_halt_gnt", 8'(count_gnt(1, 24)), 8'd24);
      run(25);
      chk("mem30_after_halt", mem[8'h30], 8'h77);

      // Reset asserted during the load-data wait
      begin_scn(8'h00, 1, 0, 8'h10, 8'h00, 0, 8'h00, 8'h00);
      poke(8'h00, 8'h20);
      poke(8'h10, 8'hAB);
      build_model(4);
      run(4);
      #1 RESET_N = 1'b0;
      #1 zero_check("mid_dwait");
      build_model(8);
      run(8);
      chk("mem10_after_abort", mem[8'h10], 8'hAB);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/arbitro_memoria.md
Name: arbitro_memoria

Overview:
- Sequencer/arbiter for the single-port 256x8 synchronous memory shared by nRisc instruction fetch, nRisc data access and an external program loader.
- Splits each nRisc instruction into fetch / execute / data / commit phases and drives a core enable (core_en) so nRisc state advances only once per completed instruction.
- Grants the loader at instruction boundaries only, with a burst limit to prevent core starvation.

Parameters:
- MAX_LD_BURST, 4: maximum consecutive loader grants before one core instruction is forced; legal range 1..15.

Ports:
- CLK  in  1  system clock, rising edge
- RESET_N  in  1  asynchronous reset, active low
- pc_addr  in  8  nRisc PC (saidaPC)
- instr_out  out  8  registered instruction to nRisc (saida_instrucao)
- core_en  out  1  one-cycle pulse; nRisc PC/register file update on this edge
- d_rd  in  1  nRisc LeMemoria
- d_wr  in  1  nRisc EscreveMemoria
- d_addr  in  8  nRisc data address
- d_wdata  in  8  nRisc store data
- d_rdata  out  8  registered load data to nRisc (valorlido)
- ld_req  in  1  loader write request, level
- ld_addr  in  8  loader address
- ld_wdata  in  8  loader data
- ld_gnt  out  1  one-cycle pulse; loader write performed this cycle
- mem_addr  out  8  memory address
- mem_wdata  out  8  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  8  memory read data, valid the cycle after the address

Behaviour:
- Reset (async, RESET_N=0): state=S_FETCH, instr_out=0, d_rdata=0, burst count=0; core_en, ld_gnt, mem_we=0; mem_addr, mem_wdata=0. Any in-flight write is aborted immediately.
- States:
  - S_FETCH: mem_addr=pc_addr, mem_we=0 -> S_FWAIT.
  - S_FWAIT: instr_out<=mem_rdata at cycle end -> S_EXEC.
  - S_EXEC: instr_out stable; nRisc decodes combinationally.
    - d_wr=1: mem_addr=d_addr, mem_wdata=d_wdata, mem_we=1 -> S_COMMIT.
    - d_rd=1 (d_wr=0): mem_addr=d_addr -> S_DWAIT.
    - Neither: -> S_COMMIT.
    - d_rd and d_wr both set: write wins, read ignored.
  - S_DWAIT: d_rdata<=mem_rdata -> S_COMMIT.
  - S_COMMIT: core_en=1 for one cycle; burst count cleared. Next: ld_req=1 -> S_LOAD, else S_FETCH.
  - S_LOAD: mem_addr=ld_addr, mem_wdata=ld_wdata, mem_we=1, ld_gnt=1; burst count +1. Next: ld_req=1 and count<MAX_LD_BURST -> S_LOAD, else S_FETCH.
  - S_HALT: entered from S_FETCH when pc_addr==8'hFF. No fetch, core_en=0. Loader served every cycle with ld_req=1; burst limit not applied. Exit only via reset.
- Latency: non-memory instruction and store = 4 cycles (FETCH..COMMIT); load = 5 cycles.
- ld_req during FETCH/FWAIT/EXEC/DWAIT is held off until after S_COMMIT; deasserting it before grant is legal, and no grant is issued.
- d_rdata holds its last load value until the next load; it is not cleared by non-load instructions.
- mem_we is never asserted outside S_EXEC (store), S_LOAD or S_HALT (load).

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined: adds output ports instr_count[15:0] (increments on each core_en) and ld_count[15:0] (increments on each ld_gnt). Both saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset release, pc_addr=0x00, mem[0x00]=0x20, no data access -> S_FETCH at cycle 0, instr_out=0x20 from cycle 2, core_en high only in cycle 3, next fetch in cycle 4.
- Load: mem[0x10]=0xAB, d_rd=1, d_addr=0x10 in EXEC -> mem_addr=0x10 in cycle 2, d_rdata=0xAB in cycle 4, core_en in cycle 4.
- Store: d_wr=1, d_addr=0x05, d_wdata=0x3C -> mem_we=1, mem_addr=0x05, mem_wdata=0x3C for exactly one cycle (cycle 2), core_en in cycle 3.
- Loader starvation, MAX_LD_BURST=4, ld_req held high -> 4 consecutive ld_gnt pulses, then one full instruction (core_en once), then 4 more grants.
- Halt: pc_addr=0xFF at S_FETCH -> core_en stays 0 for 20 cycles; ld_req with ld_addr=0x30, ld_wdata=0x77 -> ld_gnt each cycle and mem[0x30]=0x77.
- RESET_N low mid-S_DWAIT -> all outputs 0 in the same cycle; after release, S_FETCH resumes and no write occurred.
